// File: rtl/tdc_readout_seq.sv
// ---------------------------------------------------------------------------
// tdc_readout_seq : slice-serial TDC thermometer readout with popcount,
// first-zero and bubble detection on a valid/ready result port.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdc_readout_seq #(
  parameter int N_DELAY = 128,
  parameter int SETTLE  = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_trig,
  output logic [4:0]       o_sel,
  input  logic [7:0]       i_slice,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count,
  output logic             o_bubble,
  output logic [CNT_W-1:0] o_first0
);

  localparam int              N_SLICE  = N_DELAY / 8;
  localparam logic [4:0]      LAST_SEL = 5'(N_SLICE - 1);
  localparam int              SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;
  localparam logic [CNT_W-1:0] NO_ZERO = CNT_W'(N_DELAY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DECODE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // With no settle time every slice step goes straight to sampling.
  localparam state_t STEP_ST = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t           state_q;
  logic [4:0]       sel_q;
  logic [SET_W-1:0] wait_q;
  logic             busy_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             bubble_q;
  logic [CNT_W-1:0] first0_q;

  logic [CNT_W-1:0] acc_cnt_q,    acc_cnt_d;
  logic             acc_seen0_q,  acc_seen0_d;
  logic             acc_bubble_q, acc_bubble_d;
  logic [CNT_W-1:0] acc_first0_q, acc_first0_d;
  logic [CNT_W-1:0] slice_base;

  assign slice_base = CNT_W'({sel_q, 3'b000});

  // Fold the current slice into the running result, LSB first.
  always_comb begin
    acc_cnt_d    = acc_cnt_q;
    acc_seen0_d  = acc_seen0_q;
    acc_bubble_d = acc_bubble_q;
    acc_first0_d = acc_first0_q;
    for (int b = 0; b < 8; b++) begin
      acc_cnt_d = acc_cnt_d + CNT_W'(i_slice[b]);
      if (!i_slice[b]) begin
        if (!acc_seen0_d) begin
          acc_first0_d = slice_base + CNT_W'(b);
        end
        acc_seen0_d = 1'b1;
      end else if (acc_seen0_d) begin
        acc_bubble_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      bubble_q     <= 1'b0;
      first0_q     <= '0;
      acc_cnt_q    <= '0;
      acc_seen0_q  <= 1'b0;
      acc_bubble_q <= 1'b0;
      acc_first0_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_trig) begin
            acc_cnt_q    <= '0;
            acc_seen0_q  <= 1'b0;
            acc_bubble_q <= 1'b0;
            acc_first0_q <= '0;
            wait_q       <= SET_LOAD;
            busy_q       <= 1'b1;
            state_q      <= STEP_ST;
          end
        end
        ST_SETTLE: begin
          if (wait_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            wait_q <= wait_q - SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          acc_cnt_q    <= acc_cnt_d;
          acc_seen0_q  <= acc_seen0_d;
          acc_bubble_q <= acc_bubble_d;
          acc_first0_q <= acc_first0_d;
          if (sel_q == LAST_SEL) begin
            sel_q   <= '0;
            state_q <= ST_DECODE;
          end else begin
            sel_q   <= sel_q + 5'd1;
            wait_q  <= SET_LOAD;
            state_q <= STEP_ST;
          end
        end
        ST_DECODE: begin
          count_q  <= acc_cnt_q;
          bubble_q <= acc_bubble_q;
          first0_q <= acc_seen0_q ? acc_first0_q : NO_ZERO;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sel    = sel_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_count  = count_q;
  assign o_bubble = bubble_q;
  assign o_first0 = first0_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_readout_seq.sv
// ---------------------------------------------------------------------------
// tb_tdc_readout_seq : randomized bench with a cycle-level reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tdc_readout_seq;

  localparam int N_DELAY = 128;
  localparam int SETTLE  = 2;
  localparam int CNT_W   = 8;
  localparam int NS      = N_DELAY / 8;
  localparam int SCAN    = NS * (SETTLE + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_trig;
  logic [4:0]       o_sel;
  logic [7:0]       i_slice;
  logic             o_busy;
  logic             o_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_count;
  logic             o_bubble;
  logic [CNT_W-1:0] o_first0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdc_readout_seq #(
    .N_DELAY (N_DELAY),
    .SETTLE  (SETTLE),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_trig   (i_trig),
    .o_sel    (o_sel),
    .i_slice  (i_slice),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_count  (o_count),
    .o_bubble (o_bubble),
    .o_first0 (o_first0)
  );

  // Slice mux model: data is inverted until o_sel has been stable SETTLE cycles.
  logic [N_DELAY-1:0] code = '0;
  logic [4:0]         prev_sel = '0;
  int                 age = 100;
  int                 eff_age;
  logic [7:0]         true_slice;

  always @(posedge clk) begin
    if (o_sel !== prev_sel) age <= 1;
    else if (age < 100)     age <= age + 1;
    prev_sel <= o_sel;
  end

  always_comb begin
    eff_age    = (o_sel !== prev_sel) ? 0 : age;
    true_slice = code[int'(o_sel)*8 +: 8];
  end

  assign i_slice = (eff_age >= SETTLE) ? true_slice : ~true_slice;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_result(input logic [N_DELAY-1:0] c,
                                     output int cnt, output int f0, output int bub);
    logic [N_DELAY-1:0] ideal;
    cnt = 0;
    f0  = N_DELAY;
    for (int i = 0; i < N_DELAY; i++) begin
      if (c[i]) cnt++;
      else if (f0 == N_DELAY) f0 = i;
    end
    ideal = '1;
    ideal = (cnt == 0) ? '0 : (ideal >> (N_DELAY - cnt));
    bub = (c != ideal) ? 1 : 0;
  endfunction

  function automatic logic [N_DELAY-1:0] thermo(input int n);
    logic [N_DELAY-1:0] c;
    for (int i = 0; i < N_DELAY; i++) c[i] = (i < n);
    return c;
  endfunction

  // Reference model: 0 idle, 1 scanning (m_n cycles since trigger), 2 holding.
  int m_st = 0;
  int m_n  = 0;
  bit m_init = 0;
  int e_count = 0, e_first0 = 0, e_bubble = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_init = 1;
      e_count = 0; e_first0 = 0; e_bubble = 0;
    end else begin
      case (m_st)
        0: if (i_trig) begin m_st = 1; m_n = 0; end
        1: begin
          m_n++;
          if (m_n == SCAN + 1) begin
            m_st = 2;
            ref_result(code, e_count, e_first0, e_bubble);
          end
        end
        default: if (i_ready) m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("sel",    o_sel,    (m_st == 1) ? (m_n / (SETTLE + 1)) % NS : 0);
      chk("busy",   o_busy,   (m_st == 1) ? 1 : 0);
      chk("valid",  o_valid,  (m_st == 2) ? 1 : 0);
      chk("count",  o_count,  e_count);
      chk("bubble", o_bubble, e_bubble);
      chk("first0", o_first0, e_first0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_scan(input logic [N_DELAY-1:0] c, input bit noise, output int lat);
    code   = c;
    i_trig = 1'b1;
    lat    = 0;
    for (int k = 1; k <= 300; k++) begin
      tick;
      lat = k;
      if (o_valid) break;
      i_trig  = noise ? 1'($urandom) : 1'b0;
      i_ready = noise ? 1'($urandom) : 1'b0;
    end
    i_trig  = 1'b0;
    i_ready = 1'b0;
    chk("scan_valid", o_valid, 1);
  endtask

  task automatic accept;
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    i_trig  = 1'b0;
  endtask

  task automatic check_lit(input string nm, input int cnt, input int f0, input int bub);
    chk({nm, "_count"},  o_count,  cnt);
    chk({nm, "_first0"}, o_first0, f0);
    chk({nm, "_bubble"}, o_bubble, bub);
  endtask

  initial begin
    int lat;
    logic [N_DELAY-1:0] c;
    rst_n = 1'b0; i_trig = 1'b0; i_ready = 1'b0;
    repeat (3) tick;
    chk("rst_sel", o_sel, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    check_lit("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick;

    do_scan(thermo(32), 1'b0, lat);
    chk("latency_lit", lat, 50);
    check_lit("ones32", 32, 32, 0);
    accept;

    do_scan(thermo(128), 1'b0, lat);
    check_lit("all1", 128, 128, 0);
    accept;

    do_scan(thermo(0), 1'b0, lat);
    check_lit("all0", 0, 0, 0);
    accept;

    c = thermo(10); c[12] = 1'b1;
    do_scan(c, 1'b0, lat);
    check_lit("bub_in", 11, 10, 1);
    accept;

    c = thermo(8); c[20] = 1'b1;
    do_scan(c, 1'b0, lat);
    check_lit("bub_x", 9, 8, 1);

    // Held result must survive trigger noise; accept with trig high starts nothing.
    repeat (20) begin
      i_trig = 1'($urandom);
      tick;
    end
    chk("hold_valid", o_valid, 1);
    chk("hold_busy", o_busy, 0);
    check_lit("hold", 9, 8, 1);
    i_ready = 1'b1; i_trig = 1'b1;
    tick;
    i_ready = 1'b0; i_trig = 1'b0;
    chk("acc_valid", o_valid, 0);
    tick;
    chk("acc_busy", o_busy, 0);

    do_scan(thermo(45), 1'b1, lat);
    check_lit("retrig", 45, 45, 0);
    accept;

    // Reset mid-scan, then confirm no stale accumulator state leaks.
    code = thermo(100); code[3] = 1'b0;
    i_trig = 1'b1;
    tick;
    i_trig = 1'b0;
    for (int w = 0; w < 300; w++) begin
      if (o_sel == 5'd7) break;
      tick;
    end
    chk("reach_slice7", o_sel, 7);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid_rst_sel", o_sel, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_count", o_count, 0);
    tick;
    do_scan(thermo(77), 1'b0, lat);
    chk("latency", lat, SCAN + 2);
    check_lit("post_rst", 77, 77, 0);
    accept;

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: c = thermo($urandom_range(0, N_DELAY));
        1: for (int i = 0; i < N_DELAY; i++) c[i] = 1'($urandom);
        default: begin
          c = thermo($urandom_range(0, N_DELAY));
          c[$urandom_range(0, N_DELAY - 1)] ^= 1'b1;
        end
      endcase
      do_scan(c, 1'b1, lat);
      chk("rand_latency", lat, SCAN + 2);
      repeat ($urandom_range(0, 3)) begin
        i_trig = 1'($urandom);
        tick;
      end
      i_trig = 1'($urandom);
      accept;
    end

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
